order_dispatch: RTL and testbench

- Sits directly downstream of the order cache FIFO, in the system_clk domain.
- Pops one order at a time from the cache and waits for the cache's registered field outputs to settle.
- Decodes the 3-bit order code and fires a one-cycle start pulse to the matching compute engine (conv, pool, upsample, weight load, ...).
- Waits for that engine's done, then reports completion with the order id and fetches the next order. Orders are strictly serialised: one in flight at a time.

---
 rtl/order_dispatch_if.sv | 33 +++
 rtl/order_dispatch.sv | 167 ++++++++++++++++
 tb/tb_order_dispatch.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/order_dispatch_if.sv
// Order dispatch bus: the cache-side pop/field signals and the
// compute-engine start/done handshake.
interface order_dispatch_if;
    logic       pop_order_en;
    logic       order_valid;
    logic       order_valid_r;
    logic [2:0] order;
    logic [31:0] id;
    logic [5:0] engine_start;
    logic [5:0] engine_done;

    // Dispatcher side: issues pops and starts, consumes order fields and dones
    modport master (
        output pop_order_en,
        output engine_start,
        input  order_valid,
        input  order_valid_r,
        input  order,
        input  id,
        input  engine_done
    );

    // Cache / engine side
    modport slave (
        input  pop_order_en,
        input  engine_start,
        output order_valid,
        output order_valid_r,
        output order,
        output id,
        output engine_done
    );
endinterface

// File: rtl/order_dispatch.sv
// Order dispatcher: pops one order at a time from the order cache, fires a
// one-hot start to the matching compute engine, waits for its done (with an
// optional timeout) and reports completion. Strictly one order in flight.
module order_dispatch #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd16777216,
    parameter int          CNT_W          = 32
) (
    input  logic                 system_clk,
    input  logic                 rst,
    input  logic                 dispatch_en,
    input  logic                 clear_error,
    order_dispatch_if.master     bus,
    output logic                 busy,
    output logic [2:0]           cur_order,
    output logic [31:0]          cur_id,
    output logic                 order_done,
    output logic [31:0]          order_done_id,
    output logic                 fence,
    output logic [CNT_W-1:0]     done_count,
    output logic                 error
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] POP    = 3'd1;
    localparam logic [2:0] CAPT   = 3'd2;
    localparam logic [2:0] DECODE = 3'd3;
    localparam logic [2:0] RUN    = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [31:0]      tmo_q, tmo_d;
    logic [2:0]       cur_order_q, cur_order_d;
    logic [31:0]      cur_id_q, cur_id_d;
    logic             pop_q, pop_d;
    logic             busy_q, busy_d;
    logic             order_done_q, order_done_d;
    logic [31:0]      order_done_id_q, order_done_id_d;
    logic             fence_q, fence_d;
    logic [CNT_W-1:0] done_count_q, done_count_d;
    logic             error_q, error_d;
    logic             run_done;
    logic             tmo_hit;
    logic [5:0]       start_vec;

    // Only the done bit of the engine serving the order in flight counts
    always_comb begin
        run_done = 1'b0;
        if (cur_order_q >= 3'd1 && cur_order_q <= 3'd6) begin
            run_done = bus.engine_done[cur_order_q - 3'd1];
        end
    end

    // Timeout fires on the last allowed RUN cycle; a zero limit disables it
    always_comb begin
        tmo_hit = (TIMEOUT_CYCLES != 32'd0) && (tmo_q == (TIMEOUT_CYCLES - 32'd1));
    end

    // One-hot start during DECODE, decoded only from the state flop and the
    // cache's registered order field, so it is free of combinational hazards
    always_comb begin
        start_vec = 6'd0;
        if (state_q == DECODE && bus.order >= 3'd1 && bus.order <= 3'd6) begin
            start_vec = 6'd1 << (bus.order - 3'd1);
        end
    end

    // Dispatch sequencing: pop, wait for fields, decode, run, report
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        cur_order_d = cur_order_q;
        cur_id_d    = cur_id_q;
        case (state_q)
            IDLE: begin
                if (dispatch_en) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = bus.order_valid ? CAPT : IDLE;
            end
            CAPT: begin
                state_d = DECODE;
            end
            DECODE: begin
                cur_order_d = bus.order;
                cur_id_d    = bus.id;
                tmo_d       = 32'd0;
                state_d     = (bus.order == 3'd0 || bus.order == 3'd7) ? DONE : RUN;
            end
            RUN: begin
                tmo_d = tmo_q + 32'd1;
                if (run_done) begin
                    state_d = DONE;
                end else if (tmo_hit) begin
                    state_d = ERR;
                end
            end
            DONE: begin
                state_d = dispatch_en ? POP : IDLE;
            end
            ERR: begin
                if (clear_error) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the next state so they align with it
    always_comb begin
        pop_d           = (state_d == POP);
        busy_d          = (state_d != IDLE);
        order_done_d    = (state_d == DONE);
        fence_d         = (state_d == DONE) && (cur_order_d == 3'd7);
        order_done_id_d = (state_d == DONE) ? cur_id_d : order_done_id_q;
        done_count_d    = (state_d == DONE) ? (done_count_q + CNT_ONE) : done_count_q;
        error_d         = (state_d == ERR);
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            tmo_q           <= 32'd0;
            cur_order_q     <= 3'd0;
            cur_id_q        <= 32'd0;
            pop_q           <= 1'b0;
            busy_q          <= 1'b0;
            order_done_q    <= 1'b0;
            order_done_id_q <= 32'd0;
            fence_q         <= 1'b0;
            done_count_q    <= '0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            tmo_q           <= tmo_d;
            cur_order_q     <= cur_order_d;
            cur_id_q        <= cur_id_d;
            pop_q           <= pop_d;
            busy_q          <= busy_d;
            order_done_q    <= order_done_d;
            order_done_id_q <= order_done_id_d;
            fence_q         <= fence_d;
            done_count_q    <= done_count_d;
            error_q         <= error_d;
        end
    end

    assign bus.pop_order_en = pop_q;
    assign bus.engine_start = start_vec;
    assign busy             = busy_q;
    assign cur_order        = cur_order_q;
    assign cur_id           = cur_id_q;
    assign order_done       = order_done_q;
    assign order_done_id    = order_done_id_q;
    assign fence            = fence_q;
    assign done_count       = done_count_q;
    assign error            = error_q;

endmodule

// File: tb/tb_order_dispatch.sv
// Bench for order_dispatch: cache FIFO and engine models drive the DUT, event
// logs are compared against timing/ordering expectations derived per order.
module tb_order_dispatch;

    typedef struct {logic [2:0] code; logic [31:0] id;} ord_t;
    typedef struct {int c; logic [5:0] v;} start_t;
    typedef struct {int c; logic [31:0] id; logic f;} done_t;

    logic        system_clk = 1'b0;
    logic        rst;
    logic        dispatch_en;
    logic        clear_error;
    logic        busy;
    logic [2:0]  cur_order;
    logic [31:0] cur_id;
    logic        order_done;
    logic [31:0] order_done_id;
    logic        fence;
    logic [31:0] done_count;
    logic        error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_rise = -1;
    logic err_prev = 1'b0;
    int orphan_fence = 0;
    logic [31:0] exp_count = 32'd0;

    logic [34:0] fifo_q[$];
    int          fifo_count = 0;
    logic [34:0] pend;
    ord_t        exp_q[$];
    int          pop_log[$];
    start_t      start_log[$];
    done_t       done_log[$];
    int          delay_log[$];

    logic [5:0] model_done;
    logic [5:0] extra_done;
    logic [5:0] act;
    logic [5:0] fire_v;
    logic [5:0] stray_v;
    int         cnt;
    int         d_v;
    bit         hang;
    bit         stray_en;
    int         fixed_delay;

    order_dispatch_if bus_if();

    order_dispatch #(.TIMEOUT_CYCLES(32'd16), .CNT_W(32)) dut (
        .system_clk    (system_clk),
        .rst           (rst),
        .dispatch_en   (dispatch_en),
        .clear_error   (clear_error),
        .bus           (bus_if),
        .busy          (busy),
        .cur_order     (cur_order),
        .cur_id        (cur_id),
        .order_done    (order_done),
        .order_done_id (order_done_id),
        .fence         (fence),
        .done_count    (done_count),
        .error         (error)
    );

    always #5 system_clk = ~system_clk;

    // Cache model: combinational accept, valid_r one cycle later, fields
    // scrambled during CAPT and loaded with the real order for DECODE
    assign bus_if.order_valid = bus_if.pop_order_en && (fifo_count != 0);

    always @(posedge system_clk or posedge rst) begin
        if (rst) begin
            bus_if.order_valid_r <= 1'b0;
            bus_if.order         <= 3'd0;
            bus_if.id            <= 32'd0;
        end else begin
            bus_if.order_valid_r <= bus_if.order_valid;
            if (bus_if.order_valid_r) begin
                bus_if.order <= pend[34:32];
                bus_if.id    <= pend[31:0];
            end
            if (bus_if.order_valid) begin
                pend = fifo_q.pop_front();
                fifo_count = fifo_q.size();
                pop_log.push_back(cyc);
                bus_if.order <= 3'($urandom);
                bus_if.id    <= $urandom;
            end
        end
    end

    // Engine model: done on the started bit after a chosen delay, plus random
    // pulses on the other engines' done bits
    assign bus_if.engine_done = model_done | extra_done;

    always @(posedge system_clk or posedge rst) begin
        if (rst) begin
            model_done <= 6'd0;
            act = 6'd0;
            cnt = 0;
        end else begin
            fire_v = 6'd0;
            if (bus_if.engine_start != 6'd0) begin
                act = bus_if.engine_start;
                if (!hang) begin
                    d_v = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 5));
                    delay_log.push_back(d_v);
                    if (d_v == 1) fire_v = act;
                    else cnt = d_v - 1;
                end
            end else if (cnt == 1) begin
                fire_v = act;
                cnt = 0;
            end else if (cnt > 1) begin
                cnt = cnt - 1;
            end
            stray_v = (stray_en && $urandom_range(0, 3) == 0) ? (6'($urandom) & ~act) : 6'd0;
            if (fire_v != 6'd0) act = 6'd0;
            model_done <= fire_v | stray_v;
        end
    end

    // Event monitor sampling the DUT mid-cycle
    always @(negedge system_clk) begin
        cyc++;
        if (bus_if.engine_start != 6'd0) start_log.push_back('{cyc, bus_if.engine_start});
        if (order_done) done_log.push_back('{cyc, order_done_id, fence});
        if (fence && !order_done) orphan_fence++;
        if (error && !err_prev) err_rise = cyc;
        err_prev = error;
    end

    task automatic tick();
        @(negedge system_clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] code, input logic [31:0] id, input bit expect_done);
        fifo_q.push_back({code, id});
        fifo_count = fifo_q.size();
        if (expect_done) exp_q.push_back('{code, id});
    endtask

    task automatic wait_dones(input int n, input int budget, input string tag);
        int k = 0;
        while (done_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        check_output({tag, "_completions_seen"}, 64'(done_log.size() >= n), 64'd1);
        tick();
    endtask

    task automatic wait_start(input int budget, input string tag);
        int k = 0;
        while (start_log.size() == 0 && k < budget) begin
            tick();
            k++;
        end
        check_output({tag, "_start_seen"}, 64'(start_log.size() != 0), 64'd1);
    endtask

    task automatic check_orders(input int n, input string tag);
        ord_t e;
        start_t s;
        done_t dn;
        int p;
        int dc;
        int d;
        logic [5:0] one_hot;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0 || pop_log.size() == 0 || done_log.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL %s_events: observed pops=%0d completions=%0d, required %0d more orders",
                       tag, pop_log.size(), done_log.size(), n - i);
                return;
            end
            e  = exp_q.pop_front();
            p  = pop_log.pop_front();
            dc = p + 3;
            if (e.code >= 3'd1 && e.code <= 3'd6) begin
                if (start_log.size() == 0 || delay_log.size() == 0) begin
                    checks++;
                    errors++;
                    $error("[TB] FAIL %s_start[%0d]: observed no start, required code %0d", tag, i, e.code);
                end else begin
                    s = start_log.pop_front();
                    d = delay_log.pop_front();
                    one_hot = 6'd1;
                    one_hot = one_hot << (e.code - 3'd1);
                    check_output($sformatf("%s_start_vec[%0d]", tag, i), 64'(s.v), 64'(one_hot));
                    check_output($sformatf("%s_start_cyc[%0d]", tag, i), 64'(s.c), 64'(p + 2));
                    dc = p + 3 + d;
                end
            end
            dn = done_log.pop_front();
            check_output($sformatf("%s_done_id[%0d]", tag, i), 64'(dn.id), 64'(e.id));
            check_output($sformatf("%s_fence[%0d]", tag, i), 64'(dn.f), 64'(e.code == 3'd7));
            check_output($sformatf("%s_done_cyc[%0d]", tag, i), 64'(dn.c), 64'(dc));
        end
        check_output({tag, "_extra_starts"}, 64'(start_log.size()), 64'd0);
        check_output({tag, "_extra_dones"}, 64'(done_log.size()), 64'd0);
        exp_count = exp_count + 32'(n);
        check_output({tag, "_done_count"}, 64'(done_count), 64'(exp_count));
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_pop"}, 64'(bus_if.pop_order_en), 64'd0);
        check_output({tag, "_start"}, 64'(bus_if.engine_start), 64'd0);
        check_output({tag, "_busy"}, 64'(busy), 64'd0);
        check_output({tag, "_cur_order"}, 64'(cur_order), 64'd0);
        check_output({tag, "_cur_id"}, 64'(cur_id), 64'd0);
        check_output({tag, "_order_done"}, 64'(order_done), 64'd0);
        check_output({tag, "_order_done_id"}, 64'(order_done_id), 64'd0);
        check_output({tag, "_fence"}, 64'(fence), 64'd0);
        check_output({tag, "_done_count"}, 64'(done_count), 64'd0);
        check_output({tag, "_error"}, 64'(error), 64'd0);
    endtask

    // Safety net against a hung run
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence followed by a randomized order stream
    initial begin
        int pops;
        int toggle_bad;
        int busy_bad;
        int k;
        logic prev_pop;
        logic [2:0] rc;

        rst = 1'b1;
        dispatch_en = 1'b0;
        clear_error = 1'b0;
        extra_done = 6'd0;
        hang = 1'b0;
        stray_en = 1'b1;
        fixed_delay = 0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Empty FIFO: pop polled every other cycle, busy follows it
        dispatch_en = 1'b1;
        pops = 0;
        toggle_bad = 0;
        busy_bad = 0;
        prev_pop = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_if.pop_order_en === prev_pop) toggle_bad++;
            if (busy !== bus_if.pop_order_en) busy_bad++;
            if (bus_if.pop_order_en === 1'b1) pops++;
            prev_pop = bus_if.pop_order_en;
        end
        check_output("poll_pops", 64'(pops), 64'd6);
        check_output("poll_alternate", 64'(toggle_bad), 64'd0);
        check_output("poll_busy", 64'(busy_bad), 64'd0);
        check_output("poll_no_start", 64'(start_log.size()), 64'd0);
        check_output("poll_done_count", 64'(done_count), 64'd0);
        dispatch_en = 1'b0;
        repeat (3) tick();

        // Single conv-style order with a 4-cycle engine
        fixed_delay = 4;
        apply_stimulus(3'd3, 32'hA5A5_0001, 1'b1);
        dispatch_en = 1'b1;
        wait_dones(1, 60, "single");
        check_orders(1, "single");

        // NOP, fence, then a 1-cycle engine
        fixed_delay = 1;
        apply_stimulus(3'd0, 32'd10, 1'b1);
        apply_stimulus(3'd7, 32'd11, 1'b1);
        apply_stimulus(3'd1, 32'd12, 1'b1);
        wait_dones(3, 80, "seq");
        check_orders(3, "seq");

        // Foreign done pulse during RUN must be ignored
        fixed_delay = 4;
        apply_stimulus(3'd2, 32'h0000_0B02, 1'b1);
        wait_start(60, "foreign");
        tick();
        extra_done = 6'b100000;
        tick();
        extra_done = 6'd0;
        wait_dones(1, 60, "foreign");
        check_orders(1, "foreign");

        // Engine that never finishes: timeout after 16 RUN cycles
        hang = 1'b1;
        apply_stimulus(3'd4, 32'hDEAD_0004, 1'b0);
        k = 0;
        while (error !== 1'b1 && k < 80) begin
            tick();
            k++;
        end
        check_output("tmo_error", 64'(error), 64'd1);
        check_output("tmo_pop_count", 64'(pop_log.size()), 64'd1);
        if (pop_log.size() == 1) begin
            check_output("tmo_rise_cyc", 64'(err_rise), 64'(pop_log[0] + 19));
        end
        check_output("tmo_cur_order", 64'(cur_order), 64'd4);
        check_output("tmo_cur_id", 64'(cur_id), 64'hDEAD_0004);
        check_output("tmo_busy", 64'(busy), 64'd1);
        apply_stimulus(3'd5, 32'h0000_0005, 1'b1);
        repeat (8) tick();
        check_output("tmo_no_pop", 64'(pop_log.size()), 64'd1);
        check_output("tmo_no_start", 64'(start_log.size()), 64'd1);
        check_output("tmo_error_held", 64'(error), 64'd1);
        hang = 1'b0;
        clear_error = 1'b1;
        tick();
        clear_error = 1'b0;
        check_output("clr_error", 64'(error), 64'd0);
        check_output("clr_busy", 64'(busy), 64'd0);
        check_output("clr_done_count", 64'(done_count), 64'(exp_count));
        if (pop_log.size() != 0) void'(pop_log.pop_front());
        if (start_log.size() != 0) begin
            check_output("tmo_start_vec", 64'(start_log[0].v), 64'h08);
            void'(start_log.pop_front());
        end
        wait_dones(1, 60, "after_clear");
        check_orders(1, "after_clear");

        // dispatch_en dropped mid-RUN: order completes, then parks in IDLE
        fixed_delay = 5;
        apply_stimulus(3'd6, 32'h0000_0066, 1'b1);
        wait_start(60, "drop");
        dispatch_en = 1'b0;
        wait_dones(1, 60, "drop");
        check_orders(1, "drop");
        pops = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_if.pop_order_en === 1'b1) pops++;
        end
        check_output("drop_no_pop", 64'(pops), 64'd0);
        check_output("drop_busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of RUN
        fixed_delay = 8;
        apply_stimulus(3'd1, 32'h0000_0077, 1'b1);
        dispatch_en = 1'b1;
        wait_start(60, "arst");
        tick();
        tick();
        check_output("arst_pre_busy", 64'(busy), 64'd1);
        check_output("arst_pre_count", 64'(done_count), 64'(exp_count));
        rst = 1'b1;
        #1;
        check_all_zero("arst");
        exp_q.delete();
        pop_log.delete();
        start_log.delete();
        delay_log.delete();
        done_log.delete();
        fifo_q.delete();
        fifo_count = 0;
        exp_count = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Randomized order stream with random engine latencies
        fixed_delay = 0;
        for (int i = 0; i < 8; i++) begin
            rc = 3'($urandom_range(0, 7));
            apply_stimulus(rc, $urandom, 1'b1);
        end
        wait_dones(8, 400, "rand_a");
        check_orders(8, "rand_a");
        for (int i = 0; i < 10; i++) begin
            rc = 3'($urandom_range(0, 7));
            apply_stimulus(rc, $urandom, 1'b1);
        end
        wait_dones(10, 400, "rand_b");
        check_orders(10, "rand_b");

        check_output("orphan_fence", 64'(orphan_fence), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
